// File: rtl/sysid_read_arbiter.sv
// sysid_read_arbiter: two-master round-robin read arbiter and wait-state sequencer for the sysid slave.
// Define SYSID_CHECK_EN to run a boot-time read of address 0 against EXPECTED_ID before serving masters.
module sysid_read_arbiter #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] EXPECTED_ID = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_read,
  input  logic        m0_address,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic        m1_read,
  input  logic        m1_address,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        s_address,
  input  logic [31:0] s_readdata,
  output logic        id_check_done,
  output logic        id_mismatch
);
  // state      | meaning
  // IDLE       | waiting for a master read; arbitrates and latches address
  // ACCESS     | slave address held while the wait-state counter runs down
  // RESP       | winner waitrequest low for this single cycle
  // CHECK      | boot read of address 0, both masters stalled
  // CHECK_RESP | boot check result posted, returning to IDLE
  typedef enum logic [2:0] {IDLE, ACCESS, RESP, CHECK, CHECK_RESP} state_t;

  localparam int         WAIT_EFF = (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) ? 1 : WAIT_CYCLES;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_EFF - 1);

`ifdef SYSID_CHECK_EN
  localparam state_t RESET_STATE = CHECK;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_winner;
  logic        r_last_grant;
  logic        r_addr;
  logic [31:0] r_data;
  logic        r_m0_wait;
  logic        r_m1_wait;
  logic        r_done;
  logic        r_mismatch;
  logic        w_any;
  logic        w_pick;

  assign w_any  = m0_read | m1_read;
  // On a tie the master that was not served last wins; a lone requester always wins.
  assign w_pick = (m0_read & m1_read) ? ~r_last_grant : m1_read;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= RESET_STATE;
      r_cnt        <= CNT_INIT;
      r_winner     <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= 1'b0;
      r_data       <= 32'h0;
      r_m0_wait    <= 1'b1;
      r_m1_wait    <= 1'b1;
      r_done       <= 1'b0;
      r_mismatch   <= 1'b0;
    end else begin
      r_m0_wait <= 1'b1;
      r_m1_wait <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_winner <= w_pick;
            r_addr   <= w_pick ? m1_address : m0_address;
            r_cnt    <= CNT_INIT;
            r_state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_data  <= s_readdata;
            r_state <= RESP;
            if (r_winner) r_m1_wait <= 1'b0;
            else          r_m0_wait <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_last_grant <= r_winner;
          r_state      <= IDLE;
        end
`ifdef SYSID_CHECK_EN
        CHECK: begin
          if (r_cnt == 4'd0) begin
            r_done     <= 1'b1;
            r_mismatch <= (s_readdata != EXPECTED_ID);
            r_state    <= CHECK_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        CHECK_RESP: r_state <= IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_waitrequest = r_m0_wait;
  assign m1_waitrequest = r_m1_wait;
  assign m0_readdata    = r_data;
  assign m1_readdata    = r_data;
  assign s_address      = r_addr;

`ifdef SYSID_CHECK_EN
  assign id_check_done = r_done;
  assign id_mismatch   = r_mismatch;
`else
  logic w_unused_check;
  assign w_unused_check = ^{EXPECTED_ID, r_done, r_mismatch};
  assign id_check_done  = 1'b1;
  assign id_mismatch    = 1'b0;
`endif
endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Scoreboard bench for sysid_read_arbiter: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=4.
// Responses are checked in order per instance for port, data and arrival cycle.
module tb_sysid_read_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              rst_n;
  logic [3:0]        rd, ad, w_wait;
  logic [3:0][31:0]  rdata;
  logic [1:0]        s_addr, done, mism;
  logic [31:0]       id_val, ts_val, s_rd0, s_rd1;
  int checks = 0;
  int errors = 0;

  assign s_rd0 = s_addr[0] ? ts_val : id_val;
  assign s_rd1 = s_addr[1] ? ts_val : id_val;

  sysid_read_arbiter #(.WAIT_CYCLES(1), .EXPECTED_ID(32'h0000_0000)) u_dut1 (
    .clock(clk), .reset_n(rst_n),
    .m0_read(rd[0]), .m0_address(ad[0]), .m0_waitrequest(w_wait[0]), .m0_readdata(rdata[0]),
    .m1_read(rd[1]), .m1_address(ad[1]), .m1_waitrequest(w_wait[1]), .m1_readdata(rdata[1]),
    .s_address(s_addr[0]), .s_readdata(s_rd0), .id_check_done(done[0]), .id_mismatch(mism[0]));

  sysid_read_arbiter #(.WAIT_CYCLES(4), .EXPECTED_ID(32'h0000_0001)) u_dut4 (
    .clock(clk), .reset_n(rst_n),
    .m0_read(rd[2]), .m0_address(ad[2]), .m0_waitrequest(w_wait[2]), .m0_readdata(rdata[2]),
    .m1_read(rd[3]), .m1_address(ad[3]), .m1_waitrequest(w_wait[3]), .m1_readdata(rdata[3]),
    .s_address(s_addr[1]), .s_readdata(s_rd1), .id_check_done(done[1]), .id_mismatch(mism[1]));

  typedef struct {int port; logic [31:0] data; int cyc;} exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic push(input int d, input int p, input logic [31:0] data, input int c);
    exp_t e;
    e.port = p; e.data = data; e.cyc = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon_dut(input int d);
    for (int p = 0; p < 2; p++) begin
      if (w_wait[d*2+p] === 1'b0) begin
        exp_t e;
        int   qs;
        qs = (d == 0) ? q0.size() : q1.size();
        checks++;
        if (qs == 0) begin
          errors++;
          $display("FAIL unexpected_resp dut%0d m%0d: got waitrequest low at cyc %0d required high", d, p, cyc);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          if (e.port != p || rdata[d*2+p] !== e.data || (e.cyc >= 0 && e.cyc != cyc)) begin
            errors++;
            $display("FAIL resp dut%0d: got m%0d data %h cyc %0d required m%0d data %h cyc %0d",
                     d, p, rdata[d*2+p], cyc, e.port, e.data, e.cyc);
          end
        end
      end
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) mon_dut(d);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic r, input logic a);
    rd[i] = r;
    ad[i] = a;
  endtask

  task automatic wait_resp(input int i);
    bit got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (w_wait[i] === 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout idx%0d: got no response required one within 200 cycles", i);
    end
  endtask

  task automatic finish_read(input int i, input bit keep);
    @(posedge clk);
    #1;
    if (!keep) rd[i] = 1'b0;
  endtask

  task automatic reset_state_checks();
    chk("rst_wait", 32'(w_wait), 32'hF);
    chk("rst_rdata0", rdata[0], 32'h0);
    chk("rst_rdata2", rdata[2], 32'h0);
    chk("rst_saddr", 32'(s_addr), 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish required finish before 200us");
    $fatal(1);
  end

  initial begin : stim
    int p;
    int r;
    rst_n  = 1'b0;
    rd     = '0;
    ad     = '0;
    id_val = 32'h0000_0000;
    ts_val = 32'h5AA8_33BD;
    step(3);
    rst_n = 1'b1;
    r = cyc;
    reset_state_checks();
`ifdef SYSID_CHECK_EN
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_mism", 32'(mism), 32'h0);
    // Boot check: dut1 (W=1, EXPECTED 0) passes, dut4 (W=4, EXPECTED 1) flags mismatch.
    push(0, 0, 32'h0, -1);
    drive(0, 1'b1, 1'b0);
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          @(negedge clk);
          if (cyc - r == 0) chk("dut1_done_early", 32'(done[0]), 32'h0);
          if (cyc - r == 1) begin
            chk("dut1_done", 32'(done[0]), 32'h1);
            chk("dut1_mism", 32'(mism[0]), 32'h0);
          end
          if (cyc - r == 3) chk("dut4_done_early", 32'(done[1]), 32'h0);
          if (cyc - r == 4) begin
            chk("dut4_done", 32'(done[1]), 32'h1);
            chk("dut4_mism", 32'(mism[1]), 32'h1);
          end
        end
      end
      begin
        wait_resp(0);
        chk("stall_after_check", 32'(done[0]), 32'h1);
        finish_read(0, 1'b0);
      end
    join
`else
    chk("done_tied", 32'(done), 32'h3);
    chk("mism_tied", 32'(mism), 32'h0);
`endif
    step(20);
    id_val = 32'hC0DE_1D01;

    // Single read on dut1, timestamp address, low at N+2.
    p = cyc;
    push(0, 0, ts_val, p + 2);
    drive(0, 1'b1, 1'b1);
    wait_resp(0);
    finish_read(0, 1'b0);

    // Address changes after grant: latched address 1 is used.
    step(2);
    p = cyc;
    push(0, 0, ts_val, p + 2);
    drive(0, 1'b1, 1'b1);
    step(1);
    ad[0] = 1'b0;
    wait_resp(0);
    finish_read(0, 1'b0);

    // m1 drops read after grant: response cycle is still issued, then no hang.
    step(2);
    p = cyc;
    push(0, 1, id_val, p + 2);
    drive(1, 1'b1, 1'b0);
    step(1);
    rd[1] = 1'b0;
    wait_resp(1);
    step(2);

    // Both masters continuously requesting: strict alternation from m0, period 3.
    p = cyc;
    for (int k = 0; k < 16; k++)
      push(0, k % 2, (k % 2) ? ts_val : id_val, p + 2 + 3*k);
    fork
      begin
        for (int j = 0; j < 8; j++) begin
          drive(0, 1'b1, 1'b0);
          wait_resp(0);
          finish_read(0, j < 7);
        end
      end
      begin
        for (int j = 0; j < 8; j++) begin
          drive(1, 1'b1, 1'b1);
          wait_resp(1);
          finish_read(1, j < 7);
        end
      end
    join
    step(2);

    // dut4: prime s_address=1, then m1 read addr 0 holds s_address 0 for 4 cycles, low at N+5.
    p = cyc;
    push(1, 0, ts_val, p + 5);
    drive(2, 1'b1, 1'b1);
    wait_resp(2);
    finish_read(2, 1'b0);
    step(2);
    p = cyc;
    push(1, 1, id_val, p + 5);
    drive(3, 1'b1, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("saddr_hold_%0d", k), 32'(s_addr[1]), 32'h0);
    end
    wait_resp(3);
    finish_read(3, 1'b0);
    step(2);

    // Reset during dut4 ACCESS: no response pulse may appear.
    drive(2, 1'b1, 1'b1);
    step(2);
    rst_n = 1'b0;
    rd    = '0;
    step(2);
    rst_n = 1'b1;
    reset_state_checks();
    step(25);

    // After reset the tie goes to m0 first, m1 follows W+2 cycles later.
    p = cyc;
    push(1, 0, id_val, p + 5);
    push(1, 1, ts_val, p + 11);
    drive(2, 1'b1, 1'b0);
    drive(3, 1'b1, 1'b1);
    fork
      begin wait_resp(2); finish_read(2, 1'b0); end
      begin wait_resp(3); finish_read(3, 1'b0); end
    join

    step(10);
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
